// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types and constants for the CORDIC job scheduler
package cordic_pkg;

  localparam int Q16_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CORE_RST = 2'd1,
    ST_RUN      = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, scan starts at rr_ptr_i
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_req_o
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_req_o   = 1'b0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(rr_ptr_i) + k) % NUM_REQ);
      if (!any_req_o && req_i[idx]) begin
        any_req_o    = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/cordic_job_scheduler.sv
// rtl/cordic_job_scheduler.sv - shares one CORDIC core among NUM_REQ requesters
module cordic_job_scheduler
  import cordic_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int RST_CYCLES     = 2,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [Q16_W*NUM_REQ-1:0] req_theta,
  input  logic [NUM_REQ-1:0]       req_mode,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [Q16_W-1:0]         rsp_result,
  output logic                     rsp_err,
  output logic [Q16_W-1:0]         cordic_theta,
  output logic                     cordic_mode,
  output logic                     cordic_start,
  output logic                     cordic_rst,
  input  logic                     cordic_done,
  input  logic [Q16_W-1:0]         cordic_result,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_id,
  output logic [15:0]              job_count,
  output logic [15:0]              timeout_count
);

  // One counter serves both the core-reset phase and the done watchdog.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [Q16_W-1:0]   theta_q, theta_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [Q16_W-1:0]   result_q, result_d;
  logic               err_q, err_d;
  logic [15:0]        job_cnt_q, job_cnt_d;
  logic [15:0]        tmo_cnt_q, tmo_cnt_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i       (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .any_req_o   (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    theta_d    = theta_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    err_d      = err_q;
    job_cnt_d  = job_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    unique case (state_q)
      ST_IDLE: if (arb_any) begin
        theta_d    = req_theta[arb_idx*Q16_W +: Q16_W];
        mode_d     = req_mode[arb_idx];
        grant_id_d = arb_idx;
        rr_ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
        cnt_d      = CNT_W'(1);
        state_d    = ST_CORE_RST;
      end
      ST_CORE_RST: if (cnt_q == CNT_W'(RST_CYCLES)) begin
        cnt_d   = CNT_W'(1);
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Done is checked first so a done on the last allowed cycle still succeeds.
      ST_RUN: if (cordic_done) begin
        result_d  = cordic_result;
        err_d     = RESP_OKAY;
        job_cnt_d = job_cnt_q + 16'd1;
        state_d   = ST_RESP;
      end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
        result_d  = '0;
        err_d     = RESP_ERR;
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        state_d   = ST_RESP;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      ST_RESP: if (rsp_ready[grant_id_q]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      theta_q    <= '0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      job_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      theta_q    <= theta_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      err_q      <= err_d;
      job_cnt_q  <= job_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == ST_RESP) rsp_valid[grant_id_q] = 1'b1;
  end

  assign req_ready     = (state_q == ST_IDLE) ? arb_grant : '0;
  assign cordic_rst    = (state_q == ST_CORE_RST);
  assign cordic_start  = (state_q == ST_RUN);
  assign busy          = (state_q != ST_IDLE);
  assign cordic_theta  = theta_q;
  assign cordic_mode   = mode_q;
  assign rsp_result    = result_q;
  assign rsp_err       = err_q;
  assign grant_id      = grant_id_q;
  assign job_count     = job_cnt_q;
  assign timeout_count = tmo_cnt_q;

endmodule

// File: tb/tb_cordic_job_scheduler.sv
// tb/tb_cordic_job_scheduler.sv - self-checking bench for cordic_job_scheduler
module tb_cordic_job_scheduler;

  localparam int NR   = 4;
  localparam int RSTC = 2;
  localparam int TMO  = 24;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [32*NR-1:0] req_theta = '0;
  logic [NR-1:0]   req_mode = '0;
  logic [NR-1:0]   rsp_valid;
  logic [NR-1:0]   rsp_ready = '0;
  logic [31:0]     rsp_result;
  logic            rsp_err;
  logic [31:0]     cordic_theta;
  logic            cordic_mode;
  logic            cordic_start;
  logic            cordic_rst;
  logic            cordic_done = 1'b0;
  logic [31:0]     cordic_result = '0;
  logic            busy;
  logic [1:0]      grant_id;
  logic [15:0]     job_count;
  logic [15:0]     timeout_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: round-robin pointer and job outcome counters.
  int          m_rr = 0;
  int          m_jobs = 0;
  int          m_tmo = 0;
  logic [31:0] th [NR];
  logic        md [NR];
  int          core_lat = 0;
  logic [31:0] core_res = '0;
  int          run_seen = 0;
  int          glog [$];

  cordic_job_scheduler #(
    .NUM_REQ(NR), .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_theta(req_theta), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .cordic_theta(cordic_theta), .cordic_mode(cordic_mode), .cordic_start(cordic_start),
    .cordic_rst(cordic_rst), .cordic_done(cordic_done), .cordic_result(cordic_result),
    .busy(busy), .grant_id(grant_id), .job_count(job_count), .timeout_count(timeout_count)
  );

  always #5 aclk = ~aclk;

  // Core model: done raised in RUN cycle core_lat (0 = never answers).
  initial begin
    forever begin
      @(negedge aclk);
      if (cordic_rst) run_seen = 0;
      else if (cordic_start) run_seen = run_seen + 1;
      cordic_done   = cordic_start && (core_lat != 0) && (run_seen == core_lat);
      cordic_result = core_res;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] mask);
    for (int k = 0; k < NR; k++) if (mask[(m_rr + k) % NR]) return (m_rr + k) % NR;
    return -1;
  endfunction

  task automatic randomize_inputs();
    for (int i = 0; i < NR; i++) begin
      th[i] = $urandom;
      md[i] = 1'($urandom_range(0, 1));
    end
    core_res = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {req_ready, rsp_valid, cordic_start, cordic_rst, rsp_err, cordic_mode, busy, grant_id}, 64'd0);
    chk({tag, "_data"}, {rsp_result, cordic_theta}, 64'd0);
    chk({tag, "_cnt"}, {job_count, timeout_count}, 64'd0);
  endtask

  // Called with the DUT idle; checks one full job from grant to response handshake.
  task automatic run_job(input logic [NR-1:0] vmask, input int lat, input int hold);
    int g, n, rc, exp_run;
    logic [31:0] exp_res;
    logic exp_err;
    logic stable;
    g = pick(vmask);
    for (int i = 0; i < NR; i++) begin
      req_theta[32*i +: 32] = th[i];
      req_mode[i] = md[i];
    end
    core_lat  = lat;
    req_valid = vmask;
    rsp_ready = '0;
    #1;
    chk("grant_ready", 64'(req_ready), 64'd1 << g);
    @(negedge aclk);
    glog.push_back(int'(grant_id));
    chk("grant_id", 64'(grant_id), 64'(g));
    chk("theta_cap", 64'(cordic_theta), 64'(th[g]));
    chk("mode_cap", 64'(cordic_mode), 64'(md[g]));
    chk("busy_ready", {62'd0, busy, |req_ready}, 64'd2);
    rc = 0;
    n = 0;
    while (cordic_rst === 1'b1 && n < 50) begin
      rc++; n++;
      @(negedge aclk);
    end
    chk("rst_cycles", 64'(rc), 64'(RSTC));
    chk("start_rise", 64'(cordic_start), 64'd1);
    rc = 0;
    n = 0;
    while (cordic_start === 1'b1 && n < 200) begin
      rc++; n++;
      @(negedge aclk);
    end
    if (lat >= 1 && lat <= TMO) begin
      exp_run = lat; exp_res = core_res; exp_err = 1'b0; m_jobs++;
    end else begin
      exp_run = TMO; exp_res = '0; exp_err = 1'b1; m_tmo++;
    end
    chk("run_cycles", 64'(rc), 64'(exp_run));
    chk("rsp_valid", 64'(rsp_valid), 64'd1 << g);
    chk("rsp_result", 64'(rsp_result), 64'(exp_res));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    chk("start_in_resp", 64'(cordic_start), 64'd0);
    chk("counters", {32'd0, job_count, timeout_count}, {32'd0, 16'(m_jobs), 16'(m_tmo)});
    chk("theta_stable", 64'(cordic_theta), 64'(th[g]));
    if (hold > 0) begin
      stable = 1'b1;
      rsp_ready = ~(4'd1 << g);
      for (int c = 0; c < hold; c++) begin
        @(negedge aclk);
        if (rsp_valid !== 4'(1 << g) || rsp_result !== exp_res || rsp_err !== exp_err ||
            req_ready !== 4'd0 || busy !== 1'b1) stable = 1'b0;
      end
      chk("resp_backpressure", 64'(stable), 64'd1);
    end
    rsp_ready = 4'(1 << g);
    @(negedge aclk);
    rsp_ready = '0;
    chk("after_handshake", {62'd0, busy, |rsp_valid}, 64'd0);
    m_rr = (g + 1) % NR;
  endtask

  initial begin
    int n;
    logic ok;
    int exp_seq [10];
    exp_seq = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3};
    repeat (2) @(negedge aclk);
    #1;
    check_reset_outputs("reset");
    aresetn = 1'b1;
    @(negedge aclk);

    for (int j = 0; j < 6; j++) begin
      randomize_inputs();
      run_job(4'b1111, $urandom_range(1, 10), 0);
    end
    for (int j = 0; j < 4; j++) begin
      randomize_inputs();
      run_job(4'b1011, $urandom_range(1, 10), 0);
    end
    ok = 1'b1;
    for (int i = 0; i < 10; i++) if (glog[i] != exp_seq[i]) ok = 1'b0;
    chk("fair_order", 64'(ok), 64'd1);

    randomize_inputs();
    th[1] = 32'h001E_0000;
    md[1] = 1'b0;
    core_res = 32'h0000_8000;
    run_job(4'b0010, 20, 0);

    randomize_inputs();
    run_job(4'b0100, 0, 0);

    randomize_inputs();
    run_job(4'b1111, 7, 10);
    randomize_inputs();
    run_job(4'b1111, 3, 0);

    randomize_inputs();
    run_job(4'b0001, TMO, 0);
    randomize_inputs();
    run_job(4'b0010, TMO + 1, 0);
    randomize_inputs();
    run_job(4'b1000, TMO - 1, 0);

    for (int j = 0; j < 12; j++) begin
      randomize_inputs();
      run_job(4'($urandom_range(1, 15)), $urandom_range(0, 30), $urandom_range(0, 3));
    end

    randomize_inputs();
    core_lat = 0;
    req_valid = 4'b0100;
    #1;
    n = 0;
    while (cordic_start !== 1'b1 && n < 20) begin
      n++;
      @(negedge aclk);
    end
    chk("midrst_in_run", 64'(cordic_start), 64'd1);
    repeat (3) @(negedge aclk);
    req_valid = '0;
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check_reset_outputs("midrst");
    m_rr = 0; m_jobs = 0; m_tmo = 0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      if (rsp_valid !== 4'd0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("midrst_no_rsp", 64'(ok), 64'd1);
    randomize_inputs();
    run_job(4'b1001, 5, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
